// File: rtl/next_pc_pkg.sv
// Shared constants and BTB entry layout for the fetch next-PC generator.
package next_pc_pkg;

    // Default geometry. The BTB entry layout below is derived from these values,
    // so any instance must use matching PC_WIDTH / BTB_DEPTH.
    localparam int NPC_PC_WIDTH  = 64;
    localparam int NPC_BTB_DEPTH = 16;
    localparam int NPC_IDX_W     = $clog2(NPC_BTB_DEPTH);
    localparam int NPC_TAG_W     = NPC_PC_WIDTH - NPC_IDX_W - 2;

    // 2-bit saturating predictor states; bit 1 set means "predict taken".
    localparam logic [1:0] STRONG_NT = 2'd0;
    localparam logic [1:0] WEAK_NT   = 2'd1;
    localparam logic [1:0] WEAK_T    = 2'd2;
    localparam logic [1:0] STRONG_T  = 2'd3;

    localparam int INSTR_BYTES = 4;

    typedef struct packed {
        logic                    valid;
        logic [NPC_TAG_W-1:0]    tag;
        logic [NPC_PC_WIDTH-1:0] target;
        logic [1:0]              ctr;
    } btb_entry;

    // Saturating counter step toward the resolved direction.
    function automatic logic [1:0] ctr_update(input logic [1:0] ctr, input logic taken);
        if (taken) begin
            return (ctr == STRONG_T) ? STRONG_T : ctr + 2'd1;
        end
        return (ctr == STRONG_NT) ? STRONG_NT : ctr - 2'd1;
    endfunction

endpackage

// File: rtl/next_pc_unit_btb_table.sv
// Direct-mapped BTB storage: two read ports (fetch and resolve) and one write port.
// Reads are combinational from the stored array, so a write is only visible
// after the edge it lands on.
module btb_table
    import next_pc_pkg::*;
#(
    parameter int DEPTH = NPC_BTB_DEPTH,
    localparam int IW   = $clog2(DEPTH)
) (
    input  logic          CLK,
    input  logic          Reset,
    input  logic [IW-1:0] rd_idx_a_i,
    output btb_entry      rd_entry_a_o,
    input  logic [IW-1:0] rd_idx_b_i,
    output btb_entry      rd_entry_b_o,
    input  logic          wr_en_i,
    input  logic [IW-1:0] wr_idx_i,
    input  btb_entry      wr_entry_i
);

    btb_entry mem_q [DEPTH];

    // Reset wipes every entry to invalid / weak not-taken; otherwise one write per edge.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: WEAK_NT};
            end
        end else if (wr_en_i) begin
            mem_q[wr_idx_i] <= wr_entry_i;
        end
    end

    assign rd_entry_a_o = mem_q[rd_idx_a_i];
    assign rd_entry_b_o = mem_q[rd_idx_b_i];

endmodule

// File: rtl/next_pc_unit.sv
// Registered fetch PC with BTB-based next-PC prediction and branch-resolution redirect.
// Resolve interface: when ResolveValid is high the execute stage presents one
// resolved instruction for exactly that cycle; there is no back-pressure.
module next_pc_unit
    import next_pc_pkg::*;
#(
    parameter int                  PC_WIDTH  = NPC_PC_WIDTH,
    parameter int                  BTB_DEPTH = NPC_BTB_DEPTH,
    parameter logic [PC_WIDTH-1:0] RESET_PC  = '0
) (
    input  logic                CLK,
    input  logic                Reset,
    input  logic                Stall,
    output logic [PC_WIDTH-1:0] PC,
    output logic                PredTaken,
    input  logic                ResolveValid,
    input  logic [PC_WIDTH-1:0] ResolvePC,
    input  logic [PC_WIDTH-1:0] ResolveImm,
    input  logic                ResolveBranch,
    input  logic                ResolveUncond,
    input  logic                ResolveZero,
    input  logic                ResolvePredTaken,
    output logic                Flush
);

    localparam int                  IDX_W = $clog2(BTB_DEPTH);
    localparam int                  TAG_W = PC_WIDTH - IDX_W - 2;
    localparam logic [PC_WIDTH-1:0] STEP  = PC_WIDTH'(INSTR_BYTES);

    logic [PC_WIDTH-1:0] pc_q, pc_d;

    logic [IDX_W-1:0]    f_idx, r_idx;
    logic [TAG_W-1:0]    f_tag, r_tag;
    btb_entry            f_ent, r_ent, w_ent;
    logic                f_hit, r_hit, pred_taken;
    logic [PC_WIDTH-1:0] pred_next;

    logic                is_branch, actual_taken, mispredict, wr_en;
    logic [PC_WIDTH-1:0] actual_target, actual_next;

    btb_table #(.DEPTH(BTB_DEPTH)) u_btb (
        .CLK          (CLK),
        .Reset        (Reset),
        .rd_idx_a_i   (f_idx),
        .rd_entry_a_o (f_ent),
        .rd_idx_b_i   (r_idx),
        .rd_entry_b_o (r_ent),
        .wr_en_i      (wr_en),
        .wr_idx_i     (r_idx),
        .wr_entry_i   (w_ent)
    );

    // Fetch-side lookup: prediction and predicted next PC for the current PC.
    always_comb begin
        f_idx      = pc_q[IDX_W+1:2];
        f_tag      = pc_q[PC_WIDTH-1:IDX_W+2];
        f_hit      = f_ent.valid && (f_ent.tag == f_tag);
        pred_taken = f_hit && f_ent.ctr[1];
        pred_next  = pred_taken ? f_ent.target : pc_q + STEP;
    end

    // Resolve side: actual outcome and mispredict detection against the BTB state.
    always_comb begin
        r_idx         = ResolvePC[IDX_W+1:2];
        r_tag         = ResolvePC[PC_WIDTH-1:IDX_W+2];
        r_hit         = r_ent.valid && (r_ent.tag == r_tag);
        is_branch     = ResolveBranch || ResolveUncond;
        actual_taken  = ResolveUncond || (ResolveBranch && ResolveZero);
        actual_target = ResolvePC + {ResolveImm[PC_WIDTH-3:0], 2'b00};
        actual_next   = actual_taken ? actual_target : ResolvePC + STEP;
        // A taken/taken agreement is still wrong if the entry moved or was evicted.
        mispredict    = ResolveValid &&
                        ((ResolvePredTaken != actual_taken) ||
                         (ResolvePredTaken && actual_taken &&
                          (!r_hit || (r_ent.target != actual_target))));
    end

    // BTB update: allocate on taken miss, train counter/target on hit.
    always_comb begin
        wr_en = 1'b0;
        w_ent = r_ent;
        if (ResolveValid && is_branch) begin
            if (actual_taken) begin
                wr_en        = 1'b1;
                w_ent.valid  = 1'b1;
                w_ent.tag    = r_tag;
                w_ent.target = actual_target;
                w_ent.ctr    = r_hit ? ctr_update(r_ent.ctr, 1'b1) : WEAK_T;
            end else if (r_hit) begin
                wr_en        = 1'b1;
                w_ent.ctr    = ctr_update(r_ent.ctr, 1'b0);
            end
        end
    end

    // Next PC: redirect beats stall, stall beats prediction.
    always_comb begin
        if (mispredict) begin
            pc_d = actual_next;
        end else if (Stall) begin
            pc_d = pc_q;
        end else begin
            pc_d = pred_next;
        end
    end

    // Fetch PC register.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign PC        = pc_q;
    assign PredTaken = pred_taken;
    // A resolve arriving during reset is discarded, so it must not flush either.
    assign Flush     = mispredict && !Reset;

endmodule

// File: tb/tb_next_pc_unit.sv
// Directed bench for next_pc_unit: driver pushes per-cycle expectations, a
// negedge monitor pops and compares them against one of two DUT instances.
module tb_next_pc_unit;

    import next_pc_pkg::*;

    localparam int W = 68; // {sel, chk, pc[63:0], pred_taken, flush}

    logic        CLK = 1'b1;
    logic        rst_a, rst_b, stall;
    logic        rv, rbr, run, rz, rpt;
    logic [63:0] rpc, rimm;

    logic [63:0] pc_a, pc_b;
    logic        pt_a, pt_b, fl_a, fl_b;

    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           n_cmp = 0;
    int           n_err = 0;

    always #5 CLK = ~CLK;

    next_pc_unit #(.PC_WIDTH(64), .BTB_DEPTH(16), .RESET_PC(64'h100)) u_a (
        .CLK(CLK), .Reset(rst_a), .Stall(stall), .PC(pc_a), .PredTaken(pt_a),
        .ResolveValid(rv), .ResolvePC(rpc), .ResolveImm(rimm),
        .ResolveBranch(rbr), .ResolveUncond(run), .ResolveZero(rz),
        .ResolvePredTaken(rpt), .Flush(fl_a)
    );

    next_pc_unit #(.PC_WIDTH(64), .BTB_DEPTH(16), .RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) u_b (
        .CLK(CLK), .Reset(rst_b), .Stall(stall), .PC(pc_b), .PredTaken(pt_b),
        .ResolveValid(rv), .ResolvePC(rpc), .ResolveImm(rimm),
        .ResolveBranch(rbr), .ResolveUncond(run), .ResolveZero(rz),
        .ResolvePredTaken(rpt), .Flush(fl_b)
    );

    task automatic idle();
        rv = 1'b0; rpc = '0; rimm = '0; rbr = 1'b0; run = 1'b0; rz = 1'b0; rpt = 1'b0;
        stall = 1'b0;
    endtask

    task automatic res(input logic [63:0] pc, input logic [63:0] imm,
                       input logic br, input logic un, input logic z, input logic pt);
        rv = 1'b1; rpc = pc; rimm = imm; rbr = br; run = un; rz = z; rpt = pt;
    endtask

    // Queue the expected outputs for the current cycle, then advance one edge.
    task automatic cyc(input logic sel, input logic chk, input logic [63:0] epc,
                       input logic ept, input logic efl, input string nm);
        exp_q.push_back({sel, chk, epc, ept, efl});
        name_q.push_back(nm);
        @(posedge CLK);
        #1;
    endtask

    // Monitor: one expectation per cycle, sampled mid-cycle.
    initial begin
        logic [W-1:0] e;
        logic [65:0]  act;
        string        nm;
        forever begin
            @(negedge CLK);
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                if (e[66]) begin
                    act = e[67] ? {pc_b, pt_b, fl_b} : {pc_a, pt_a, fl_a};
                    n_cmp++;
                    if (act !== e[65:0]) begin
                        n_err++;
                        $display("FAIL %s: got pc=%h pt=%b flush=%b, want pc=%h pt=%b flush=%b",
                                 nm, act[65:2], act[1], act[0], e[65:2], e[1], e[0]);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    localparam logic [63:0] M4  = 64'hFFFF_FFFF_FFFF_FFFC;
    localparam logic [63:0] M1  = 64'hFFFF_FFFF_FFFF_FFFF;

    initial begin
        idle();
        rst_a = 1'b1;
        rst_b = 1'b1;

        // ---- Reset and free-running fetch (RESET_PC = 0x100)
        cyc(0, 0, 64'h0,   0, 0, "rst0");
        cyc(0, 1, 64'h100, 0, 0, "reset_pc");
        rst_a = 1'b0;
        cyc(0, 1, 64'h100, 0, 0, "free0");
        cyc(0, 1, 64'h104, 0, 0, "free1");
        // ---- Stall holds PC
        stall = 1'b1; cyc(0, 1, 64'h108, 0, 0, "stall_start");
        stall = 1'b1; cyc(0, 1, 64'h108, 0, 0, "stall_hold1");
        stall = 1'b1; cyc(0, 1, 64'h108, 0, 0, "stall_hold2");
        idle();       cyc(0, 1, 64'h108, 0, 0, "stall_release");
        // Redirect wins over stall (stale-alias non-branch at 0x200 -> 0x204)
        idle(); stall = 1'b1; res(64'h200, 64'h0, 0, 0, 0, 1);
        cyc(0, 1, 64'h10C, 0, 1, "stall_redirect");
        // ---- Cold unconditional branch 0x40 -> 0x30
        idle(); res(64'h40, M4, 0, 1, 0, 0);
        cyc(0, 1, 64'h204, 0, 1, "cold_taken_flush");
        idle();
        cyc(0, 1, 64'h30, 0, 0, "redirect_0x30");
        cyc(0, 1, 64'h34, 0, 0, "seq_34");
        cyc(0, 1, 64'h38, 0, 0, "seq_38");
        cyc(0, 1, 64'h3C, 0, 0, "seq_3c");
        cyc(0, 1, 64'h40, 1, 0, "btb_hit_0x40");
        // ---- CBZ at 0x80 (target 0xA0), aliases index 0 over the 0x40 entry
        idle(); res(64'h80, 64'h8, 1, 0, 1, 0);
        cyc(0, 1, 64'h30, 0, 1, "pred_target_0x30");
        idle(); res(64'h80, 64'h8, 1, 0, 1, 1);
        cyc(0, 1, 64'hA0, 0, 0, "cbz_taken2");
        idle(); res(64'h80, 64'h8, 1, 0, 1, 1);
        cyc(0, 1, 64'hA4, 0, 0, "cbz_taken3");
        idle(); res(64'h80, 64'h8, 1, 0, 0, 1);
        cyc(0, 1, 64'hA8, 0, 1, "cbz_nt_flush");
        idle(); res(64'h7C, 64'h0, 0, 0, 0, 1);
        cyc(0, 1, 64'h84, 0, 1, "nt_redirect_0x84");
        idle(); res(64'h80, 64'h8, 1, 0, 0, 1);
        cyc(0, 1, 64'h80, 1, 1, "still_pred_taken");
        idle(); res(64'h7C, 64'h0, 0, 0, 0, 1);
        cyc(0, 1, 64'h84, 0, 1, "nt2_redirect_0x84");
        // ---- Aliasing: 0x0 then 0x40 share index 0
        idle(); res(64'h0, 64'h4, 0, 1, 0, 0);
        cyc(0, 1, 64'h80, 0, 1, "pred_dropped");
        idle(); res(64'h40, M4, 0, 1, 0, 0);
        cyc(0, 1, 64'h10, 0, 1, "alias_alloc");
        idle(); res(M4, 64'h0, 0, 0, 0, 1);
        cyc(0, 1, 64'h30, 0, 1, "wrap_redirect");
        idle();
        cyc(0, 1, 64'h0, 0, 0, "alias_miss");
        // ---- Mid-stream reset discards resolve and wipes BTB
        idle(); rst_a = 1'b1; res(64'h200, 64'h4, 0, 1, 0, 0);
        cyc(0, 1, 64'h4, 0, 0, "reset_gates_flush");
        idle(); rst_a = 1'b0; res(64'h3C, 64'h0, 0, 0, 0, 1);
        cyc(0, 1, 64'h100, 0, 1, "after_reset");
        idle();
        cyc(0, 1, 64'h40, 0, 0, "btb_wiped");

        // ---- Wrap instance (RESET_PC = 2^64-4)
        rst_a = 1'b1;
        idle(); rst_b = 1'b0;
        cyc(1, 1, M4, 0, 0, "wrap_reset_pc");
        idle(); res(64'h0, M1, 0, 1, 0, 0);
        cyc(1, 1, 64'h0, 0, 1, "wrap_pc_plus4");
        idle();
        cyc(1, 1, M4, 0, 0, "wrap_target");
        cyc(1, 1, 64'h0, 1, 0, "wrap_hit");
        cyc(1, 1, M4, 0, 0, "wrap_pred_next");

        @(negedge CLK);
        #1;
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
